// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-bus initiator.
// Frame layout is {rw, addr[6:0], data[7:0]}, transmitted MSB first.
package spi_reg_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;

   localparam logic RW_WRITE = 1'b1;

   // Register map of the on-chip SPI register peripheral
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD,
      GAP
   } state_t;

   function automatic logic [FRAME_W-1:0] make_frame(input logic              rw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
      return {rw, addr, data};
   endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Counts CLK_DIV clk cycles per sclk half-period; expire pulses on the last cycle.
// restart holds the count at zero so the next phase starts a full period.
module spi_half_period_timer #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic expire
);

   localparam int                CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign expire = !restart && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || restart || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator: one register command per valid/ready handshake, 16-bit frame.
// Optional SPI_REG_READBACK_EN adds cipo capture of the data byte on read frames.
module spi_reg_writer
   import spi_reg_pkg::*;
#(
   parameter int CLK_DIV    = 50,
   parameter int GAP_CYCLES = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              ncs,
   output logic              sclk,
   output logic              copi,
   output logic              busy,
`ifdef SPI_REG_READBACK_EN
   input  logic              cipo,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
`endif
   output logic              done
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   // Handshake: a command transfers on any clk edge where req_valid && req_ready;
   // req_ready is high only in IDLE, so req_* may change freely once accepted.
   state_t               state;
   logic [FRAME_W-1:0]   shift_q;
   logic [3:0]           bit_cnt;
   logic [3:0]           bit_nxt;
   logic [GAP_W-1:0]     gap_cnt;
   logic                 accept;
   logic                 phase_done;
   logic                 timer_restart;

   assign accept        = req_valid && req_ready;
   assign bit_nxt       = bit_cnt + 4'd1;
   assign timer_restart = (state == IDLE) || (state == GAP);

   spi_half_period_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (timer_restart),
      .expire  (phase_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_q   <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         ncs       <= 1'b1;
         sclk      <= 1'b0;
         copi      <= 1'b0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  shift_q   <= make_frame(req_rw, req_addr, req_data);
                  bit_cnt   <= '0;
                  copi      <= req_rw;
                  ncs       <= 1'b0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (phase_done) begin
                  sclk  <= 1'b1;
                  state <= HIGH;
               end
            end
            HIGH: begin
               if (phase_done) begin
                  sclk    <= 1'b0;
                  bit_cnt <= bit_nxt;
                  // Bit counter wrapping to zero marks the 16th rising edge
                  if (bit_nxt == 4'd0) begin
                     state <= HOLD;
                  end else begin
                     shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
                     copi    <= shift_q[FRAME_W-2];
                     state   <= LOW;
                  end
               end
            end
            LOW: begin
               if (phase_done) begin
                  sclk  <= 1'b1;
                  state <= HIGH;
               end
            end
            HOLD: begin
               if (phase_done) begin
                  ncs     <= 1'b1;
                  copi    <= 1'b0;
                  done    <= 1'b1;
                  gap_cnt <= '0;
                  state   <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_REG_READBACK_EN
   logic [DATA_W-1:0] rd_shift;
   logic              is_read;
   logic              sclk_rise;

   // The edge that raises sclk is the peripheral's launch-to-sample point for cipo
   assign sclk_rise = phase_done && ((state == SETUP) || (state == LOW));

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_shift <= '0;
         is_read  <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if ((state == IDLE) && accept) begin
            is_read <= (req_rw != RW_WRITE);
         end
         // Rising edges 9..16 arrive with bit_cnt 8..15: these carry data bits 7..0
         if (is_read && sclk_rise && bit_cnt[3]) begin
            rd_shift <= {rd_shift[DATA_W-2:0], cipo};
         end
         if ((state == HOLD) && phase_done && is_read) begin
            rd_data  <= rd_shift;
            rd_valid <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer: SPI slave/peripheral model with frame and done scoreboards.
// Build with SPI_REG_READBACK_EN defined to also check cipo readback.
module tb_spi_reg_writer;

   localparam int D       = 2;
   localparam int G       = 3;
   localparam int LOW_CYC = 33 * D;
   localparam int DONE_AT = 33 * D + 1;
   localparam int SPACING = 33 * D + G + 1;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_rw    = 1'b0;
   logic [6:0] req_addr  = '0;
   logic [7:0] req_data  = '0;
   logic       req_ready;
   logic       ncs;
   logic       sclk;
   logic       copi;
   logic       busy;
   logic       done;
`ifdef SPI_REG_READBACK_EN
   logic       cipo = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [7:0] slave_byte = 8'hA5;
`endif

   spi_reg_writer #(
      .CLK_DIV    (D),
      .GAP_CYCLES (G)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .ncs       (ncs),
      .sclk      (sclk),
      .copi      (copi),
      .busy      (busy),
`ifdef SPI_REG_READBACK_EN
      .cipo      (cipo),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
`endif
      .done      (done)
   );

   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];
   logic        rd_q[$];
   int          acc_q[$];

   int          cyc       = 0;
   int          last_acc  = 0;
   bit          have_acc  = 1'b0;
   int          r         = 0;
   logic [15:0] sh        = '0;
   int          low_cnt   = 0;
   int          high_cnt  = 0;
   bit          in_frame  = 1'b0;
   bit          had_frame = 1'b0;
   logic        prev_ncs  = 1'b1;
   logic        prev_sclk = 1'b0;
   int          aborts    = 0;
   int          frames_ok = 0;
   int          dones     = 0;
   int          reads     = 0;
   logic [7:0]  regs [5]  = '{default: 8'h00};
   logic [7:0]  exp_regs [5] = '{8'hFF, 8'h00, 8'hFF, 8'h3C, 8'h80};

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endfunction

   // Monitor: slave decode, peripheral model, accept/done timing, readback
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         acc_q.delete();
         have_acc = 1'b0;
      end else if (req_valid && req_ready) begin
         if (have_acc) check("accept_spacing_ok", 32'(cyc - last_acc >= SPACING), 1);
         last_acc = cyc;
         have_acc = 1'b1;
         acc_q.push_back(cyc);
      end

      if (!ncs && !rst) begin
         if (prev_ncs) begin
            if (had_frame) check("ncs_gap_ok", 32'(high_cnt >= G), 1);
            in_frame = 1'b1;
            r        = 0;
            sh       = '0;
            low_cnt  = 0;
         end
         low_cnt++;
         if (sclk && !prev_sclk) begin
            sh = {sh[14:0], copi};
            r++;
         end
      end else if (ncs) begin
         if (in_frame) begin
            in_frame  = 1'b0;
            had_frame = 1'b1;
            high_cnt  = 0;
            if (exp_q.size() == 0) begin
               check("frame_expected", 0, 1);
            end else if (r == 16) begin
               check("frame_bits", 32'(sh), 32'(exp_q.pop_front()));
               check("ncs_low_cycles", low_cnt, LOW_CYC);
               frames_ok++;
               if (sh[15] && (int'(sh[14:8]) <= 4)) regs[int'(sh[14:8])] = sh[7:0];
            end else begin
               aborts++;
               void'(exp_q.pop_front());
               if (rd_q.size() != 0) void'(rd_q.pop_front());
            end
         end
         high_cnt++;
      end

      if (done && !rst) begin
         dones++;
         if (acc_q.size() == 0) begin
            check("done_expected", 0, 1);
         end else begin
            check("done_latency", cyc - acc_q.pop_front(), DONE_AT);
            check("busy_at_done", 32'(busy), 1);
            check("ready_at_done", 32'(req_ready), 0);
            if (rd_q.size() != 0) begin
               if (rd_q.pop_front()) begin
                  reads++;
`ifdef SPI_REG_READBACK_EN
                  check("rd_valid_read", 32'(rd_valid), 1);
                  check("rd_data", 32'(rd_data), 32'(slave_byte));
               end else begin
                  check("rd_valid_write", 32'(rd_valid), 0);
`endif
               end
            end
         end
      end
`ifdef SPI_REG_READBACK_EN
      if (rd_valid && !done) check("rd_valid_with_done", 32'(done), 1);
      cipo = (!ncs && r >= 8 && r < 16) ? slave_byte[15 - r] : 1'b0;
`endif
      prev_ncs  = ncs;
      prev_sclk = sclk;
   end

   task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] data);
      int n;
      exp_q.push_back({rw, addr, data});
      rd_q.push_back(!rw);
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = addr;
      req_data  = data;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_rw    = 1'($urandom_range(0, 1));
      req_addr  = 7'($urandom_range(0, 127));
      req_data  = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || acc_q.size() != 0 || !req_ready) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("idle_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("idle_ncs", 32'(ncs), 1);
      check("idle_sclk", 32'(sclk), 0);
      check("idle_copi", 32'(copi), 0);
      check("idle_ready", 32'(req_ready), 1);
      check("idle_busy", 32'(busy), 0);
      check("idle_done_count", dones, 0);
`ifdef SPI_REG_READBACK_EN
      check("idle_rd_data", 32'(rd_data), 0);
      check("idle_rd_valid", 32'(rd_valid), 0);
`endif

      send(1'b1, 7'h04, 8'h80);
      wait_idle();

      send(1'b1, 7'h00, 8'hFF);
      send(1'b1, 7'h02, 8'hFF);
      send(1'b1, 7'h04, 8'h80);
      wait_idle();

      send(1'b1, 7'h01, 8'h5A);
      n = 0;
      @(negedge clk);
      #1;
      while (r < 7 && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 1000) check("edge7_timeout", 0, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ncs", 32'(ncs), 1);
      check("rst_sclk", 32'(sclk), 0);
      check("rst_copi", 32'(copi), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ready", 32'(req_ready), 1);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_idle();

      send(1'b1, 7'h03, 8'h3C);
      wait_idle();

      send(1'b0, 7'h02, 8'h00);
      wait_idle();
      repeat (5) @(posedge clk);

      for (int i = 0; i < 5; i++) check($sformatf("reg_%0d", i), 32'(regs[i]), 32'(exp_regs[i]));
      check("aborted_frames", aborts, 1);
      check("complete_frames", frames_ok, 6);
      check("done_pulses", dones, 6);
      check("read_frames", reads, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
